// File: rtl/rv32i_types.sv
// Shared types and sizes for the burst-memory arbiter: FSM states, transfer
// owner encoding and cacheline/beat geometry.
package rv32i_types;

  localparam int BEATS  = 4;
  localparam int ADDR_W = 32;
  localparam int BEAT_W = 64;
  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_CMD   = 3'd1,
    ST_RD_BEATS = 3'd2,
    ST_WR_BEATS = 3'd3,
    ST_RESP     = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // Memory transfers are always cacheline aligned (32-byte lines).
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

endpackage

// File: rtl/bmem_arbiter_chk.sv
// Simulation checks on the cache-side request protocol of bmem_arbiter.
module bmem_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic d_read,
  input logic d_write,
  input logic i_resp,
  input logic d_resp
);

  a_no_dual_d_req: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("bmem_arbiter: d_read and d_write asserted together");

  a_single_resp: assert property (@(posedge clk) disable iff (rst) !(i_resp && d_resp))
    else $error("bmem_arbiter: both responses asserted");

endmodule

// File: rtl/line_beat_buf.sv
// Cacheline staging register: loads a whole line, writes one 64-bit beat at a
// time, and exposes a selectable beat slice plus the full line.
module line_beat_buf
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              wr_en,
  input  logic [1:0]        wr_idx,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [1:0]        rd_idx,
  output logic [BEAT_W-1:0] rd_beat,
  output logic [LINE_W-1:0] line
);

  logic [LINE_W-1:0] line_r;

  // Whole-line load wins over a single-beat write; both never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_r <= {LINE_W{1'b0}};
    end else if (load) begin
      line_r <= load_line;
    end else if (wr_en) begin
      line_r[BEAT_W*wr_idx +: BEAT_W] <= wr_beat;
    end else begin
      line_r <= line_r;
    end
  end

  assign rd_beat = line_r[BEAT_W*rd_idx +: BEAT_W];
  assign line    = line_r;

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one 64-bit burst memory port between I-cache and D-cache, one 4-beat
// cacheline at a time. Define BMEM_ARB_RR_EN for round-robin arbitration;
// otherwise the D-cache has fixed priority.
module bmem_arbiter
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  arb_state_t  state_r;
  arb_owner_t  owner_r;
  logic [1:0]  beat_r;
  arb_owner_t  grant_s;
  logic        req_any_s;
  logic        grant_wr_s;
  logic        buf_load_s;
  logic        buf_wr_s;
  logic [1:0]  buf_rd_idx_s;
  logic [BEAT_W-1:0] buf_rd_beat_s;
  logic [LINE_W-1:0] buf_line_s;

`ifdef BMEM_ARB_RR_EN
  arb_owner_t prio_r;

  // Priority passes to the other cache once a transfer completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= OWN_D;
    end else if (state_r == ST_RESP) begin
      prio_r <= (owner_r == OWN_D) ? OWN_I : OWN_D;
    end else begin
      prio_r <= prio_r;
    end
  end
`endif

  // Winner selection and staging-buffer controls.
  always_comb begin
    grant_s   = OWN_D;
    req_any_s = i_read | d_read | d_write;
    if (i_read && (d_read || d_write)) begin
`ifdef BMEM_ARB_RR_EN
      grant_s = prio_r;
`else
      grant_s = OWN_D;
`endif
    end else if (i_read) begin
      grant_s = OWN_I;
    end else begin
      grant_s = OWN_D;
    end
    grant_wr_s   = (grant_s == OWN_D) && d_write;
    buf_load_s   = (state_r == ST_IDLE) && req_any_s && grant_wr_s;
    buf_wr_s     = (state_r == ST_RD_BEATS) && bmem_rvalid;
    buf_rd_idx_s = beat_r + 2'd1;
  end

  line_beat_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load_s),
    .load_line (d_wdata),
    .wr_en     (buf_wr_s),
    .wr_idx    (beat_r),
    .wr_beat   (bmem_rdata),
    .rd_idx    (buf_rd_idx_s),
    .rd_beat   (buf_rd_beat_s),
    .line      (buf_line_s)
  );

  // Transfer FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_D;
      beat_r     <= 2'd0;
      i_rdata    <= {LINE_W{1'b0}};
      d_rdata    <= {LINE_W{1'b0}};
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
      bmem_addr  <= {ADDR_W{1'b0}};
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= {BEAT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          beat_r <= 2'd0;
          if (req_any_s) begin
            owner_r   <= grant_s;
            bmem_addr <= line_align((grant_s == OWN_I) ? i_addr : d_addr);
            if (grant_wr_s) begin
              state_r    <= ST_WR_BEATS;
              bmem_write <= 1'b1;
              bmem_wdata <= d_wdata[BEAT_W-1:0];
            end else begin
              state_r   <= ST_RD_CMD;
              bmem_read <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_CMD: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state_r   <= ST_RD_BEATS;
          end else begin
            state_r <= ST_RD_CMD;
          end
        end
        ST_RD_BEATS: begin
          if (bmem_rvalid) begin
            beat_r <= beat_r + 2'd1;
            if (beat_r == 2'd3) begin
              state_r <= ST_RESP;
              if (owner_r == OWN_I) begin
                i_resp  <= 1'b1;
                i_rdata <= {bmem_rdata, buf_line_s[3*BEAT_W-1:0]};
              end else begin
                d_resp  <= 1'b1;
                d_rdata <= {bmem_rdata, buf_line_s[3*BEAT_W-1:0]};
              end
            end else begin
              state_r <= ST_RD_BEATS;
            end
          end else begin
            state_r <= ST_RD_BEATS;
          end
        end
        ST_WR_BEATS: begin
          if (bmem_ready) begin
            if (beat_r == 2'd3) begin
              beat_r     <= 2'd0;
              bmem_write <= 1'b0;
              bmem_wdata <= {BEAT_W{1'b0}};
              d_resp     <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              beat_r     <= beat_r + 2'd1;
              bmem_wdata <= buf_rd_beat_s;
              state_r    <= ST_WR_BEATS;
            end
          end else begin
            state_r <= ST_WR_BEATS;
          end
        end
        ST_RESP: begin
          i_resp  <= 1'b0;
          d_resp  <= 1'b0;
          beat_r  <= 2'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  bmem_arbiter_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .d_read  (d_read),
    .d_write (d_write),
    .i_resp  (i_resp),
    .d_resp  (d_resp)
  );

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed scoreboard bench for bmem_arbiter; expected owner and fill line of
// each transfer are queued at request time and checked at the response pulse.
module tb_bmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  i_addr;
  logic         i_read;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr;
  logic         d_read;
  logic         d_write;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  bmem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_addr      (i_addr),
    .i_read      (i_read),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_addr      (d_addr),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  typedef struct {
    logic         is_d;
    logic         is_rd;
    logic [255:0] line;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] beat_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_resp(input string tag, input int max_wait, input int exp_wait);
    int n = 0;
    exp_t e;
    while (!(i_resp || d_resp) && n < max_wait) begin
      tick();
      n++;
    end
    if (!(i_resp || d_resp)) begin
      chk({tag, " timeout"}, 256'(n), 256'(exp_wait));
      return;
    end
    chk({tag, " latency"}, 256'(n), 256'(exp_wait));
    if (sb_q.size() == 0) begin
      chk({tag, " unexpected resp"}, 256'(sb_q.size()), 256'(1));
      return;
    end
    e = sb_q.pop_front();
    chk({tag, " d_resp"}, 256'(d_resp), 256'(e.is_d));
    chk({tag, " i_resp"}, 256'(i_resp), 256'(!e.is_d));
    if (e.is_rd) chk({tag, " rdata"}, e.is_d ? d_rdata : i_rdata, e.line);
    tick();
    chk({tag, " resp pulse"}, 256'(i_resp | d_resp), 256'(0));
  endtask

  task automatic read_tx(input string tag, input logic exp_d, input logic [31:0] exp_addr,
                         input logic [63:0] base);
    exp_t e;
    e.is_d  = exp_d;
    e.is_rd = 1'b1;
    e.line  = {base + 64'd3, base + 64'd2, base + 64'd1, base};
    sb_q.push_back(e);
    tick();
    chk({tag, " bmem_read"}, 256'(bmem_read), 256'(1));
    chk({tag, " bmem_addr"}, 256'(bmem_addr), 256'(exp_addr));
    tick();
    chk({tag, " bmem_read pulse"}, 256'(bmem_read), 256'(0));
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = base + 64'(k);
      tick();
    end
    bmem_rvalid = 1'b0;
    bmem_rdata  = 64'd0;
    do_resp(tag, 20, 0);
  endtask

  task automatic write_tx(input string tag, input logic [31:0] addr, input logic [255:0] line,
                          input int stall_beat, input int stall_cycles);
    exp_t e;
    e.is_d  = 1'b1;
    e.is_rd = 1'b0;
    e.line  = 256'd0;
    sb_q.push_back(e);
    for (int k = 0; k < 4; k++) beat_q.push_back(line[64*k +: 64]);
    d_addr  = addr;
    d_wdata = line;
    d_write = 1'b1;
    tick();
    chk({tag, " bmem_addr"}, 256'(bmem_addr), 256'(addr & 32'hFFFF_FFE0));
    for (int k = 0; k < 4; k++) begin
      if (k == stall_beat) begin
        bmem_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          chk({tag, " stall write"}, 256'(bmem_write), 256'(1));
          chk({tag, " stall wdata"}, 256'(bmem_wdata), 256'(beat_q[0]));
          tick();
        end
        bmem_ready = 1'b1;
      end
      chk({tag, " bmem_write"}, 256'(bmem_write), 256'(1));
      chk({tag, " wdata"}, 256'(bmem_wdata), 256'(beat_q.pop_front()));
      tick();
    end
    chk({tag, " write end"}, 256'(bmem_write), 256'(0));
    do_resp(tag, 20, 0);
    d_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; i_addr = 32'd0; i_read = 1'b0; d_addr = 32'd0; d_read = 1'b0;
    d_write = 1'b0; d_wdata = 256'd0; bmem_ready = 1'b1; bmem_rdata = 64'd0; bmem_rvalid = 1'b0;
    repeat (3) tick();
    chk("reset bmem_read", 256'(bmem_read), 256'(0));
    chk("reset bmem_write", 256'(bmem_write), 256'(0));
    chk("reset bmem_addr", 256'(bmem_addr), 256'(0));
    chk("reset resp", 256'({i_resp, d_resp}), 256'(0));
    chk("reset rdata", i_rdata | d_rdata, 256'd0);
    rst = 1'b0;
    tick();
    chk("idle no cmd", 256'(bmem_read | bmem_write), 256'(0));

    // I-cache read alone
    i_addr = 32'h0000_1040; i_read = 1'b1;
    read_tx("i_read", 1'b0, 32'h0000_1040, 64'hA0A0_0000_0000_000A);
    i_read = 1'b0;
    tick();
    chk("i_read no regrant", 256'(bmem_read), 256'(0));
    chk("i_rdata held", i_rdata,
        {64'hA0A0_0000_0000_000D, 64'hA0A0_0000_0000_000C, 64'hA0A0_0000_0000_000B, 64'hA0A0_0000_0000_000A});

    // D-cache writebacks, with and without a stalled beat
    write_tx("d_write", 32'h0000_2000, {64'd3, 64'd2, 64'd1, 64'd0}, 9, 0);
    write_tx("d_write stall", 32'h0000_2400,
             {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 64'h0F0F_0F0F_0F0F_0F0F}, 1, 3);

    // Reset part-way through a read, then stray beats
    i_addr = 32'h0000_3000; i_read = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = 64'hDEAD_0000_0000_0000 + 64'(k);
      tick();
    end
    bmem_rvalid = 1'b0;
    rst = 1'b1; i_read = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst rdata", i_rdata, 256'd0);
    chk("midrst cmd", 256'({bmem_read, bmem_write}), 256'(0));
    chk("midrst addr", 256'(bmem_addr), 256'(0));
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = 64'hBAD0_0000_0000_0000 + 64'(k);
      tick();
      chk("stray rvalid resp", 256'({i_resp, d_resp}), 256'(0));
      chk("stray rvalid cmd", 256'(bmem_read), 256'(0));
    end
    bmem_rvalid = 1'b0;
    bmem_rdata  = 64'd0;

    // Unaligned address is line-aligned on the memory side
    i_addr = 32'h0000_101C; i_read = 1'b1;
    read_tx("unaligned", 1'b0, 32'h0000_1000, 64'h5500_0000_0000_0000);
    i_read = 1'b0;

    // Both caches requesting continuously
    i_addr = 32'h0000_4000; d_addr = 32'h0000_5000; i_read = 1'b1; d_read = 1'b1;
    read_tx("arb1", 1'b1, 32'h0000_5000, 64'h0100);
`ifdef BMEM_ARB_RR_EN
    read_tx("arb2", 1'b0, 32'h0000_4000, 64'h0200);
`else
    read_tx("arb2", 1'b1, 32'h0000_5000, 64'h0200);
`endif
    read_tx("arb3", 1'b1, 32'h0000_5000, 64'h0300);
    d_read = 1'b0;
    read_tx("arb4", 1'b0, 32'h0000_4000, 64'h0400);
    i_read = 1'b0;
    tick();

    chk("scoreboard drained", 256'(sb_q.size() + beat_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
